// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner and the LED-counter top.
// Holds the FSM state encoding, the 12 MHz default cycle constants and a
// helper used to size the shared timer.
package btn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DEB_PRESS   = 3'd1,
    ST_HELD        = 3'd2,
    ST_REPEAT      = 3'd3,
    ST_DEB_RELEASE = 3'd4
  } btn_state_e;

  // Defaults for a 12 MHz clock: 20 ms debounce, 0.5 s repeat delay, 0.1 s period.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 240000;
  localparam int unsigned DEF_REPEAT_DELAY    = 6000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 1200000;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
// Ports:
//   CLK   - system clock
//   RSTN  - synchronous active-low reset, clears both flops
//   d_i   - asynchronous input
//   q_o   - synchronized output, two cycles behind d_i
module sync_2ff (
  input  logic CLK,
  input  logic RSTN,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_tick_gen.sv
// Push-button conditioner: synchronizes a raw bouncing button, debounces it
// with a shared up-counter and emits a one-cycle TICK per accepted press,
// plus optional auto-repeat TICKs while the button stays held.
// Ports:
//   CLK     - system clock
//   RSTN    - synchronous active-low reset
//   SW      - raw button, active-high, asynchronous
//   TICK    - registered one-cycle pulse per press / repeat
//   PRESSED - registered debounced button level
//
// state       | meaning
// ------------+----------------------------------------------------------
// IDLE        | button released and accepted as released
// DEB_PRESS   | sw_s high, waiting for it to stay high through debounce
// HELD        | press accepted, counting the initial repeat delay
// REPEAT      | auto-repeating, one TICK every repeat period
// DEB_RELEASE | sw_s low, waiting for it to stay low through debounce
module button_tick_gen
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic SW,
  output logic TICK,
  output logic PRESSED
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;

  localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_TC  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_TC  = CNT_W'(REPEAT_PERIOD - 1);

  logic             sw_s;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             tick_q, tick_d;
  logic             pressed_q, pressed_d;

  sync_2ff u_sync (
    .CLK  (CLK),
    .RSTN (RSTN),
    .d_i  (SW),
    .q_o  (sw_s)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + CNT_W'(1);
    tick_d    = 1'b0;
    pressed_d = pressed_q;

    // A change of sw_s is tested before every terminal count, so it wins.
    case (state_q)
      ST_IDLE: begin
        timer_d   = '0;
        pressed_d = 1'b0;
        if (sw_s) state_d = ST_DEB_PRESS;
      end
      ST_DEB_PRESS: begin
        if (!sw_s) begin
          state_d = ST_IDLE;
        end else if (timer_q == DEB_TC) begin
          state_d   = ST_HELD;
          tick_d    = 1'b1;
          pressed_d = 1'b1;
        end
      end
      ST_HELD: begin
        if (!sw_s) begin
          state_d = ST_DEB_RELEASE;
        end else if (!REPEAT_EN) begin
          timer_d = '0;
        end else if (timer_q == RD_TC) begin
          state_d = ST_REPEAT;
          tick_d  = 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!sw_s) begin
          state_d = ST_DEB_RELEASE;
        end else if (timer_q == RP_TC) begin
          tick_d  = 1'b1;
          timer_d = '0;
        end
      end
      ST_DEB_RELEASE: begin
        if (sw_s) begin
          state_d = ST_HELD;
        end else if (timer_q == DEB_TC) begin
          state_d   = ST_IDLE;
          pressed_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        timer_d   = '0;
        pressed_d = 1'b0;
      end
    endcase

    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      tick_q    <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      tick_q    <= tick_d;
      pressed_q <= pressed_d;
    end
  end

  assign TICK    = tick_q;
  assign PRESSED = pressed_q;

endmodule

// File: tb/tb_button_tick_gen.sv
module tb_button_tick_gen;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn = 1'b0;
  logic sw   = 1'b0;
  logic tick0, pr0, tick1, pr1;

  button_tick_gen #(.DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1'b0),
                    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut0 (
    .CLK(clk), .RSTN(rstn), .SW(sw), .TICK(tick0), .PRESSED(pr0));

  button_tick_gen #(.DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1'b1),
                    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut1 (
    .CLK(clk), .RSTN(rstn), .SW(sw), .TICK(tick1), .PRESSED(pr1));

  typedef struct packed {
    logic t0;
    logic p0;
    logic t1;
    logic p1;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;
  int   tick_cnt0 = 0;
  int   tick_cnt1 = 0;

  // Reference model: input delayed two cycles, run length of the delayed
  // level, and the number of cycles spent continuously held since the
  // press was accepted (or since a release bounce ended).
  logic m_d1, m_d2, m_last, m_pr;
  int   m_run, m_age;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic model_step(input logic s, input logic r, output exp_t e);
    logic ss;
    e = '0;
    if (!r) begin
      m_d1 = 0; m_d2 = 0; m_last = 0; m_pr = 0; m_run = 0; m_age = 0;
    end else begin
      ss   = m_d2;
      m_d2 = m_d1;
      m_d1 = s;
      if (ss == m_last) m_run++;
      else begin m_run = 1; m_last = ss; end
      if (!m_pr) begin
        if (ss && m_run == DEB + 1) begin
          m_pr = 1; m_age = 0; e.t0 = 1; e.t1 = 1;
        end
      end else if (!ss) begin
        if (m_run == DEB + 1) m_pr = 0;
      end else begin
        if (m_run == 1) m_age = 0;
        else m_age++;
        if (m_age >= RD && ((m_age - RD) % RP) == 0) e.t1 = 1;
      end
      e.p0 = m_pr;
      e.p1 = m_pr;
    end
  endtask

  task automatic drive_cycle(input logic s, input logic r);
    exp_t e;
    @(negedge clk);
    sw   = s;
    rstn = r;
    model_step(s, r, e);
    sb_q.push_back(e);
  endtask

  task automatic drv(input logic s, input int n);
    repeat (n) drive_cycle(s, 1'b1);
  endtask

  // Monitor: every cycle the DUTs present a fresh registered output.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("tick_norep", tick0, e.t0);
        chk("pressed_norep", pr0, e.p0);
        chk("tick_rep", tick1, e.t1);
        chk("pressed_rep", pr1, e.p1);
        if (tick0 === 1'b1) tick_cnt0++;
        if (tick1 === 1'b1) tick_cnt1++;
      end
    end
  end

  int base0, base1;

  task automatic phase_start();
    base0 = tick_cnt0;
    base1 = tick_cnt1;
  endtask

  task automatic phase_end(input string nm, input int exp0, input int exp1);
    chk_int({nm, "_ticks_norep"}, tick_cnt0 - base0, exp0);
    chk_int({nm, "_ticks_rep"}, tick_cnt1 - base1, exp1);
  endtask

  initial begin
    m_d1 = 0; m_d2 = 0; m_last = 0; m_pr = 0; m_run = 0; m_age = 0;

    // Reset held with SW high, then a single press.
    phase_start();
    repeat (3) drive_cycle(1'b1, 1'b0);
    drv(1'b1, 10);
    drv(1'b0, 12);
    phase_end("reset", 1, 1);

    // Bounce shorter than the debounce window.
    phase_start();
    repeat (5) begin
      drv(1'b1, 3);
      drv(1'b0, 2);
    end
    drv(1'b0, 10);
    phase_end("bounce", 0, 0);

    // Long clean press.
    phase_start();
    drv(1'b1, 50);
    drv(1'b0, 12);
    phase_end("long_press", 1, 13);

    // 30-cycle press: press tick plus six repeats.
    phase_start();
    drv(1'b1, 30);
    drv(1'b0, 12);
    phase_end("auto_repeat", 1, 7);

    // Release bounce while held restarts the repeat delay.
    phase_start();
    drv(1'b1, 12);
    drv(1'b0, 2);
    drv(1'b1, 20);
    drv(1'b0, 12);
    phase_end("release_bounce", 1, 5);

    // Reset one cycle before a due repeat tick.
    phase_start();
    drv(1'b1, 21);
    drive_cycle(1'b1, 1'b0);
    drv(1'b1, 14);
    drv(1'b0, 12);
    phase_end("mid_reset", 2, 4);

    // Randomized runs with occasional resets.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 39) == 0) drive_cycle(1'($urandom_range(0, 1)), 1'b0);
      else drv(1'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
    end
    drv(1'b0, 12);

    @(posedge clk);
    #2;
    chk_int("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
